// File: rtl/clk_gen_prog_pkg.sv
// Shared types and helpers for the programmable clock/pulse generator.
// CFG_CNT_W fixes the counter width carried in ch_cfg_t; the top's CNT_W must match it.
package clk_gen_prog_pkg;

   localparam int CFG_CNT_W = 16;

   typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} ch_state_t;

   typedef struct packed {
      logic [CFG_CNT_W-1:0] period;
      logic [CFG_CNT_W-1:0] high;
      logic [CFG_CNT_W-1:0] phase;
   } ch_cfg_t;

   localparam logic [CFG_CNT_W-1:0] CNT_ONE = 1;

   // Only meaningful when has_low(cfg) is true.
   function automatic logic [CFG_CNT_W-1:0] low_time(input ch_cfg_t cfg);
      return cfg.period - cfg.high;
   endfunction

   function automatic logic has_low(input ch_cfg_t cfg);
      return cfg.high < cfg.period;
   endfunction

   // A zero high time still occupies one HIGH cycle so the FSM keeps cycling.
   function automatic logic [CFG_CNT_W-1:0] high_load(input ch_cfg_t cfg);
      return (cfg.high == '0) ? '0 : cfg.high - CNT_ONE;
   endfunction

   function automatic logic drives_high(input ch_cfg_t cfg);
      return (cfg.period != '0) && (cfg.high != '0);
   endfunction

endpackage

// File: rtl/clk_gen_prog_ch.sv
// One generator channel: state machine, down-counter, active/shadow settings
// with glitch-free handover at period boundaries, and rise edge detect.
module clk_gen_prog_ch
   import clk_gen_prog_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    wr,
   input  ch_cfg_t cfg_in,
   input  logic    start,
   input  logic    stop,
   output logic    ready,
   output logic    clk_out,
   output logic    rise_tick,
   output logic    busy
);

   ch_state_t            state, state_n;
   logic [CFG_CNT_W-1:0] cnt, cnt_n;
   ch_cfg_t              act, act_n, shd, shd_n, base, eff;
   logic                 pend, pend_n;
   logic                 stop_pend, stop_pend_n;
   logic                 load_new;
   logic                 clk_out_n, clk_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         act       <= '0;
         shd       <= '0;
         pend      <= 1'b0;
         stop_pend <= 1'b0;
         clk_out   <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         act       <= act_n;
         shd       <= shd_n;
         pend      <= pend_n;
         stop_pend <= stop_pend_n;
         clk_out   <= clk_out_n;
         clk_out_q <= clk_out;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt - CNT_ONE;
      stop_pend_n = stop_pend;
      load_new    = 1'b0;
      // An idle channel takes writes straight into its active settings,
      // so a same-cycle start already sees them through base.
      base = (state == IDLE && wr) ? cfg_in : act;
      eff  = pend ? shd : base;

      case (state)
         IDLE: begin
            cnt_n       = cnt;
            stop_pend_n = 1'b0;
            if (start && !stop) begin
               load_new = 1'b1;
               if (eff.phase == '0) begin
                  state_n = HIGH;
                  cnt_n   = high_load(eff);
               end else begin
                  state_n = PHASE;
                  cnt_n   = eff.phase - CNT_ONE;
               end
            end else begin
               load_new = pend;
            end
         end
         PHASE: begin
            if (stop) begin
               state_n  = IDLE;
               load_new = 1'b1;
            end else if (cnt == '0) begin
               state_n = HIGH;
               cnt_n   = high_load(act);
            end
         end
         HIGH: begin
            // A stop seen mid-pulse is remembered so the pulse is never truncated.
            if (stop) stop_pend_n = 1'b1;
            if (cnt == '0) begin
               if (stop || stop_pend) begin
                  state_n     = IDLE;
                  stop_pend_n = 1'b0;
                  load_new    = 1'b1;
               end else if (has_low(act)) begin
                  state_n = LOW;
                  cnt_n   = low_time(act) - CNT_ONE;
               end else begin
                  load_new = 1'b1;
                  cnt_n    = high_load(eff);
               end
            end
         end
         LOW: begin
            if (stop) begin
               state_n  = IDLE;
               load_new = 1'b1;
            end else if (cnt == '0) begin
               state_n  = HIGH;
               load_new = 1'b1;
               cnt_n    = high_load(eff);
            end
         end
         default: state_n = IDLE;
      endcase

      act_n  = load_new ? eff : base;
      shd_n  = shd;
      pend_n = pend;
      if (load_new) pend_n = 1'b0;
      if (wr && state != IDLE) begin
         shd_n  = cfg_in;
         pend_n = 1'b1;
      end
      clk_out_n = (state_n == HIGH) && drives_high(act_n);
   end

   assign ready     = !pend;
   assign busy      = (state != IDLE);
   assign rise_tick = clk_out & ~clk_out_q;

endmodule

// File: rtl/clk_gen_prog.sv
// Runtime-programmable multi-channel clock/pulse generator: NUM_CH independent
// channels sharing one configuration port, each with period/high/phase settings.
module clk_gen_prog
   import clk_gen_prog_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [CNT_W-1:0]  cfg_phase,
   input  logic [NUM_CH-1:0] start,
   input  logic [NUM_CH-1:0] stop,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] rise_tick,
   output logic [NUM_CH-1:0] busy
);

   ch_cfg_t           cfg_in;
   logic [NUM_CH-1:0] ready;

   assign cfg_in = '{period: cfg_period, high: cfg_high, phase: cfg_phase};

   always_comb begin
      cfg_ready = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = ready[i];
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_gen_prog_ch u_ch (
         .clk       (clk),
         .rst       (rst),
         .wr        (cfg_valid && ready[i] && (cfg_ch == CH_W'(i))),
         .cfg_in    (cfg_in),
         .start     (start[i]),
         .stop      (stop[i]),
         .ready     (ready[i]),
         .clk_out   (clk_out[i]),
         .rise_tick (rise_tick[i]),
         .busy      (busy[i])
      );
   end

endmodule

// File: tb/tb_clk_gen_prog.sv
// Bench for clk_gen_prog: directed scenarios push expected edge times into
// per-channel queues; a negedge monitor matches every observed edge against them.
module tb_clk_gen_prog;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;
   localparam int CH_W   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_period = '0;
   logic [CNT_W-1:0]  cfg_high = '0;
   logic [CNT_W-1:0]  cfg_phase = '0;
   logic [NUM_CH-1:0] start = '0;
   logic [NUM_CH-1:0] stop = '0;
   logic [NUM_CH-1:0] clk_out, rise_tick, busy;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int exp_q [NUM_CH][$];
   logic [NUM_CH-1:0] prev = '0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   clk_gen_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_phase  (cfg_phase),
      .start      (start),
      .stop       (stop),
      .clk_out    (clk_out),
      .rise_tick  (rise_tick),
      .busy       (busy)
   );

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
   endtask

   // Edge codes: cycle*2 for a rise, cycle*2+1 for a fall.
   task automatic expect_edge(input int ch, input int at, input int fall);
      exp_q[ch].push_back(at * 2 + fall);
   endtask

   task automatic expect_wave(input int ch, input int rise, input int hi, input int per, input int n);
      for (int k = 0; k < n; k++) begin
         expect_edge(ch, rise + k * per, 0);
         expect_edge(ch, rise + k * per + hi, 1);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [NUM_CH-1:0] m);
      start = m;
      @(negedge clk);
      start = '0;
   endtask

   task automatic pulse_stop(input logic [NUM_CH-1:0] m);
      stop = m;
      @(negedge clk);
      stop = '0;
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic cfg_write(input int ch, input int p, input int h, input int ph, output int acc);
      cfg_valid  = 1'b1;
      cfg_ch     = CH_W'(ch);
      cfg_period = CNT_W'(p);
      cfg_high   = CNT_W'(h);
      cfg_phase  = CNT_W'(ph);
      acc = -1;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (cfg_ready) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) check("cfg_write_timeout", 0, 1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (clk_out[ch] != prev[ch]) begin
               if (exp_q[ch].size() == 0)
                  check($sformatf("unexpected_edge_ch%0d", ch), cyc * 2 + int'(prev[ch]), -1);
               else
                  check($sformatf("edge_ch%0d", ch), cyc * 2 + int'(prev[ch]), exp_q[ch].pop_front());
            end
            check($sformatf("rise_tick_ch%0d", ch), rise_tick[ch], clk_out[ch] & ~prev[ch]);
            prev[ch] = clk_out[ch];
         end
      end
   end

   initial begin
      int c, r, s, d, e, g, h, k, acc;

      repeat (3) @(negedge clk);
      check("rst_clk_out", clk_out, 0);
      check("rst_rise_tick", rise_tick, 0);
      check("rst_busy", busy, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Basic waveform 10/3/0 on ch0
      cfg_write(0, 10, 3, 0, acc);
      c = cyc;
      expect_wave(0, c + 1, 3, 10, 3);
      pulse_start(4'b0001);
      check("basic_busy", busy[0], 1);
      wait_until(c + 26);
      pulse_stop(4'b0001);
      check("basic_stop_in_low", busy[0], 0);

      // Phase alignment: ch1 trails ch0 by 2 cycles
      cfg_write(0, 8, 4, 0, acc);
      cfg_write(1, 8, 4, 2, acc);
      s = cyc;
      expect_wave(0, s + 1, 4, 8, 3);
      expect_wave(1, s + 3, 4, 8, 3);
      pulse_start(4'b0011);
      wait_until(s + 22);
      pulse_stop(4'b0011);
      check("phase_stop_busy", busy[1:0], 0);

      // Glitch-free reconfiguration
      cfg_write(0, 10, 5, 0, acc);
      r = cyc;
      expect_wave(0, r + 1, 5, 10, 2);
      expect_edge(0, r + 21, 0);
      expect_edge(0, r + 22, 1);
      expect_edge(0, r + 25, 0);
      expect_edge(0, r + 27, 1);
      expect_edge(0, r + 31, 0);
      expect_edge(0, r + 33, 1);
      pulse_start(4'b0001);
      wait_until(r + 12);
      cfg_write(0, 4, 1, 0, acc);
      check("reconf_first_accept", acc, r + 12);
      #1;
      check("reconf_ready_low", cfg_ready, 0);
      cfg_valid = 1'b1;
      cfg_period = 16'd6;
      cfg_high = 16'd2;
      wait_until(r + 20);
      #1;
      check("reconf_second_stalls", cfg_ready, 0);
      cfg_write(0, 6, 2, 0, acc);
      check("reconf_second_accept", acc, r + 21);
      wait_until(r + 34);
      pulse_stop(4'b0001);
      check("reconf_stop_busy", busy[0], 0);

      // Degenerate high=0: constant low, busy while started
      cfg_write(2, 10, 0, 0, acc);
      d = cyc;
      pulse_start(4'b0100);
      check("h0_busy", busy[2], 1);
      wait_until(d + 5);
      check("h0_clk_low", clk_out[2], 0);
      check("h0_busy_later", busy[2], 1);
      pulse_stop(4'b0100);
      check("h0_stopped", busy[2], 0);

      // Degenerate high>=period with phase 3: constant high, one rise
      cfg_write(3, 10, 12, 3, acc);
      e = cyc;
      expect_edge(3, e + 4, 0);
      expect_edge(3, e + 52, 1);
      pulse_start(4'b1000);
      wait_until(e + 3);
      check("hge_phase_low", clk_out[3], 0);
      check("hge_phase_busy", busy[3], 1);
      wait_until(e + 40);
      check("hge_held_high", clk_out[3], 1);
      pulse_stop(4'b1000);
      wait_until(e + 51);
      check("hge_finishing_high", clk_out[3], 1);
      @(negedge clk);
      check("hge_idle", busy[3], 0);

      // Stop during the 2nd of 5 high cycles
      cfg_write(0, 10, 5, 0, acc);
      g = cyc;
      expect_wave(0, g + 1, 5, 10, 1);
      pulse_start(4'b0001);
      @(negedge clk);
      pulse_stop(4'b0001);
      wait_until(g + 5);
      check("stop_high_kept", clk_out[0], 1);
      check("stop_high_busy", busy[0], 1);
      @(negedge clk);
      check("stop_high_idle", busy[0], 0);
      start = 4'b0001;
      stop = 4'b0001;
      @(negedge clk);
      start = '0;
      stop = '0;
      check("start_stop_same", busy[0], 0);
      repeat (3) @(negedge clk);
      check("start_stop_stays", busy[0], 0);

      // Reset while two channels are high
      cfg_write(0, 10, 5, 0, acc);
      cfg_write(1, 10, 5, 0, acc);
      h = cyc;
      expect_edge(0, h + 1, 0);
      expect_edge(1, h + 1, 0);
      expect_edge(0, h + 4, 1);
      expect_edge(1, h + 4, 1);
      pulse_start(4'b0011);
      wait_until(h + 3);
      check("pre_rst_high", clk_out[1:0], 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_clk_out", clk_out, 0);
      check("mid_rst_busy", busy, 0);
      cfg_ch = 2'd0;
      #1;
      check("mid_rst_ready", cfg_ready, 1);
      @(negedge clk);
      pulse_start(4'b0001);
      repeat (4) @(negedge clk);
      check("cleared_cfg_low", clk_out[0], 0);
      check("cleared_cfg_busy", busy[0], 1);
      pulse_stop(4'b0001);
      check("cleared_cfg_stop", busy[0], 0);
      cfg_write(0, 10, 5, 0, acc);
      k = cyc;
      expect_wave(0, k + 1, 5, 10, 1);
      pulse_start(4'b0001);
      wait_until(k + 8);
      pulse_stop(4'b0001);
      check("restart_stop", busy[0], 0);

      repeat (5) @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++)
         check($sformatf("missing_edges_ch%0d", ch), exp_q[ch].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
